serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first,
// through an IDLE/SHIFT/DONE sequencer with registered status and result outputs.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bw;
    logic [CNT_W-1:0] r_cnt;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_bw_next;
    logic [WIDTH-1:0] w_res_next;

    // Full subtractor on the current LSBs; the result fills from the MSB side so
    // that after WIDTH shifts bit 0 of the operands lands in bit 0 of the result.
    assign w_a0       = r_a[0];
    assign w_b0       = r_b[0];
    assign w_d        = w_a0 ^ w_b0 ^ r_bw;
    assign w_bw_next  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bw);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    // NOTE: every register in this block uses non-blocking assignment so all of
    // them update together from pre-edge values, matching real flip-flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_bw       <= 1'b0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_res   <= '0;
                        r_bw    <= borrow_in;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_bw  <= w_bw_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        diff       <= w_res_next;
                        borrow_out <= w_bw_next;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16: directed
// corner cases followed by random regressions, scored against a queue model.

module tb_serial_subtractor;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          total;
    int          bad;

    logic        start8, bin8, busy8, done8, bo8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, busy16, done16, bo16;
    logic [15:0] a16, b16, diff16;

    exp_t        q8[$];
    exp_t        q16[$];
    int          busy_run8, busy_run16;
    logic        done8_q, done16_q;
    int          done_cnt8;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .borrow_in(bin8), .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .borrow_in(bin16), .busy(busy16), .done(done16), .diff(diff16),
        .borrow_out(bo16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Scoreboard checkers: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (done8) begin
            check("w8_busy_len", 64'(busy_run8), 64'd8);
            check("w8_done_while_busy", {63'd0, busy8}, 64'd0);
            check("w8_done_two_cycles", {63'd0, done8_q}, 64'd0);
            check("w8_done_expected", {63'd0, q8.size() != 0}, 64'd1);
            if (q8.size() != 0) begin
                exp_t e;
                e = q8.pop_front();
                check("w8_diff", {56'd0, diff8}, {32'd0, e.d});
                check("w8_borrow_out", {63'd0, bo8}, {63'd0, e.bo});
                check("w8_latency", 64'(cyc - e.acc), 64'd8);
            end
            done_cnt8 <= done_cnt8 + 1;
        end
        busy_run8 <= busy8 ? busy_run8 + 1 : 0;
        done8_q   <= done8;
    end

    always @(negedge clk) begin
        if (done16) begin
            check("w16_busy_len", 64'(busy_run16), 64'd16);
            check("w16_done_while_busy", {63'd0, busy16}, 64'd0);
            check("w16_done_two_cycles", {63'd0, done16_q}, 64'd0);
            check("w16_done_expected", {63'd0, q16.size() != 0}, 64'd1);
            if (q16.size() != 0) begin
                exp_t e;
                e = q16.pop_front();
                check("w16_diff", {48'd0, diff16}, {32'd0, e.d});
                check("w16_borrow_out", {63'd0, bo16}, {63'd0, e.bo});
                check("w16_latency", 64'(cyc - e.acc), 64'd16);
            end
        end
        busy_run16 <= busy16 ? busy_run16 + 1 : 0;
        done16_q   <= done16;
    end

    task automatic push8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input int acc);
        logic [8:0] r;
        exp_t       e;
        r     = {1'b0, ia} - {1'b0, ib} - {8'd0, ibin};
        e.d   = {24'd0, r[7:0]};
        e.bo  = r[8];
        e.acc = acc;
        q8.push_back(e);
    endtask

    task automatic push16(input logic [15:0] ia, input logic [15:0] ib, input logic ibin, input int acc);
        logic [16:0] r;
        exp_t        e;
        r     = {1'b0, ia} - {1'b0, ib} - {16'd0, ibin};
        e.d   = {16'd0, r[15:0]};
        e.bo  = r[16];
        e.acc = acc;
        q16.push_back(e);
    endtask

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while ((busy8 || done8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("w8_idle_timeout", 64'(n), 64'd0);
    endtask

    task automatic wait_idle16();
        int n = 0;
        @(negedge clk);
        while ((busy16 || done16) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("w16_idle_timeout", 64'(n), 64'd0);
    endtask

    // Issues one single-cycle start from IDLE, then scrambles the inputs while
    // the operation is in flight; returns 1 ns after the accepting edge.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
        wait_idle8();
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        push8(ia, ib, ibin, cyc + 1);
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    endtask

    task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input logic ibin);
        wait_idle16();
        a16 = ia; b16 = ib; bin16 = ibin; start16 = 1'b1;
        push16(ia, ib, ibin, cyc + 1);
        @(posedge clk); #1;
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("w8_drain", 64'(q8.size()), 64'd0);
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("w16_drain", 64'(q16.size()), 64'd0);
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc != target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("cycle_wait_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        int n;
        logic [7:0]  ops_a [3];
        logic [7:0]  ops_b [3];
        logic        ops_c [3];

        total = 0; bad = 0; done_cnt8 = 0;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;

        // Reset state.
        #12;
        check("rst_busy8", {63'd0, busy8}, 64'd0);
        check("rst_done8", {63'd0, done8}, 64'd0);
        check("rst_diff8", {56'd0, diff8}, 64'd0);
        check("rst_bo8", {63'd0, bo8}, 64'd0);
        check("rst_diff16", {48'd0, diff16}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic and boundary subtractions.
        op8(8'h05, 8'h03, 1'b0);
        wait_idle8();
        check("idle_hold_diff", {56'd0, diff8}, 64'h02);
        op8(8'h03, 8'h05, 1'b0);
        repeat (3) @(negedge clk);
        check("shift_hold_diff", {56'd0, diff8}, 64'h02);
        check("shift_hold_bo", {63'd0, bo8}, 64'd0);
        check("shift_busy", {63'd0, busy8}, 64'd1);
        op8(8'h00, 8'h00, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'h00, 8'hFF, 1'b1);

        // start during DONE must be ignored.
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {63'd0, done8}, 64'd1);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        check("done_start_ignored", {63'd0, busy8}, 64'd0);

        // Second start during SHIFT is ignored.
        op8(8'h80, 8'h01, 1'b0);
        repeat (2) @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; bin8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = done_cnt8;
        drain8();
        repeat (4) @(negedge clk);
        check("single_done_pulse", 64'(done_cnt8 - n), 64'd1);
        check("shift_start_diff", {56'd0, diff8}, 64'h7F);

        // Asynchronous reset in the middle of SHIFT.
        op8(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy8}, 64'd0);
        check("arst_done", {63'd0, done8}, 64'd0);
        check("arst_diff", {56'd0, diff8}, 64'd0);
        check("arst_bo", {63'd0, bo8}, 64'd0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = done_cnt8;
        repeat (20) @(negedge clk);
        check("arst_no_done", 64'(done_cnt8 - n), 64'd0);
        check("arst_diff_held", {56'd0, diff8}, 64'd0);
        op8(8'h0A, 8'h01, 1'b0);
        drain8();
        check("post_reset_diff", {56'd0, diff8}, 64'h09);

        // start held high: acceptances every WIDTH+2 cycles.
        ops_a[0] = 8'h12; ops_b[0] = 8'h34; ops_c[0] = 1'b1;
        ops_a[1] = 8'hC8; ops_b[1] = 8'h37; ops_c[1] = 1'b0;
        ops_a[2] = 8'h01; ops_b[2] = 8'h01; ops_c[2] = 1'b1;
        wait_idle8();
        n = done_cnt8;
        acc0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_cyc(acc0 + (k - 1) * 10);
            a8 = ops_a[k]; b8 = ops_b[k]; bin8 = ops_c[k]; start8 = 1'b1;
            push8(ops_a[k], ops_b[k], ops_c[k], acc0 + k * 10);
        end
        wait_cyc(acc0 + 20);
        start8 = 1'b0;
        drain8();
        repeat (3) @(negedge clk);
        check("b2b_done_count", 64'(done_cnt8 - n), 64'd3);

        // Random regressions with random idle gaps.
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        drain8();
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op16(16'($urandom), 16'($urandom), 1'($urandom));
        end
        op16(16'h0000, 16'hFFFF, 1'b1);
        op16(16'hFFFF, 16'h0000, 1'b0);
        drain16();

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
